// File: rtl/video_scanout_controller.sv
// video_scanout_controller
// VGA raster engine. Walks the screen with an h/v counter pair, issues one
// framebuffer read per visible pixel, and delays visibility, syncs and the
// frame enable so they line up with the colour returned RD_LATENCY cycles
// after each request.
module video_scanout_controller #(
    parameter int H_VIS_AREA_PXL    = 800,
    parameter int H_FRONT_PORCH_PXL = 40,
    parameter int H_SYNC_PULSE_PXL  = 128,
    parameter int H_BACK_PORCH_PXL  = 88,
    parameter int V_VIS_AREA_PXL    = 600,
    parameter int V_FRONT_PORCH_PXL = 1,
    parameter int V_SYNC_PULSE_PXL  = 4,
    parameter int V_BACK_PORCH_PXL  = 23,
    parameter int HS_ACTIVE_HIGH    = 1,
    parameter int VS_ACTIVE_HIGH    = 1,
    parameter int SCALE_SHIFT       = 1,
    parameter int RD_LATENCY        = 1,
    parameter int RED_BITS          = 4,
    parameter int GREEN_BITS        = 4,
    parameter int BLUE_BITS         = 4,
    localparam int COLOR_BITS       = RED_BITS + GREEN_BITS + BLUE_BITS,
    localparam int FB_W             = H_VIS_AREA_PXL >> SCALE_SHIFT,
    localparam int FB_H             = V_VIS_AREA_PXL >> SCALE_SHIFT,
    localparam int X_BITS           = (FB_W > 1) ? $clog2(FB_W) : 1,
    localparam int Y_BITS           = (FB_H > 1) ? $clog2(FB_H) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  flip_x_i,
    input  logic                  flip_y_i,
    input  logic [COLOR_BITS-1:0] border_color_i,
    output logic [X_BITS-1:0]     fb_rd_x_o,
    output logic [Y_BITS-1:0]     fb_rd_y_o,
    output logic                  fb_rd_en_o,
    input  logic [COLOR_BITS-1:0] color_i,
    output logic                  vga_hs_o,
    output logic                  vga_vs_o,
    output logic [RED_BITS-1:0]   vga_r_o,
    output logic [GREEN_BITS-1:0] vga_g_o,
    output logic [BLUE_BITS-1:0]  vga_b_o,
    output logic                  frame_start_o,
    output logic                  vblank_o
);

    localparam int H_TOTAL  = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
    localparam int V_TOTAL  = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;
    localparam int H_BITS   = $clog2(H_TOTAL);
    localparam int V_BITS   = $clog2(V_TOTAL);
    // one request register stage plus the framebuffer read latency
    localparam int L        = 1 + RD_LATENCY;
    localparam int HS_START = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL;
    localparam int HS_END   = HS_START + H_SYNC_PULSE_PXL;
    localparam int VS_START = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL;
    localparam int VS_END   = VS_START + V_SYNC_PULSE_PXL;

    logic [H_BITS-1:0]     h_cnt;
    logic [V_BITS-1:0]     v_cnt;
    logic                  h_last;
    logic                  v_last;
    logic                  at_origin;

    logic                  en_lat;
    logic                  fx_lat;
    logic                  fy_lat;
    logic                  frame_en;
    logic                  frame_fx;
    logic                  frame_fy;

    logic                  h_vis;
    logic                  v_vis;
    logic                  vis;
    logic                  hs_raw;
    logic                  vs_raw;
    logic [H_BITS-1:0]     h_scaled;
    logic [V_BITS-1:0]     v_scaled;
    logic [X_BITS-1:0]     x_clamp;
    logic [Y_BITS-1:0]     y_clamp;
    logic [X_BITS-1:0]     x_req;
    logic [Y_BITS-1:0]     y_req;

    logic [L-1:0]          vis_pipe;
    logic [L-1:0]          en_pipe;
    logic [L-1:0]          hs_pipe;
    logic [L-1:0]          vs_pipe;
    logic                  hs_d;
    logic                  vs_d;
    logic [COLOR_BITS-1:0] pixel;

    assign h_last    = (h_cnt == H_BITS'(H_TOTAL - 1));
    assign v_last    = (v_cnt == V_BITS'(V_TOTAL - 1));
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // The frame controls are captured at the origin, but the origin pixel itself
    // must already obey the new values, so it bypasses the latch.
    assign frame_en = at_origin ? enable_i : en_lat;
    assign frame_fx = at_origin ? flip_x_i : fx_lat;
    assign frame_fy = at_origin ? flip_y_i : fy_lat;

    // Raster counters: h sweeps a full line, v advances once per line wrap.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Hold enable and flip settings constant for a whole frame.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            en_lat <= 1'b0;
            fx_lat <= 1'b0;
            fy_lat <= 1'b0;
        end else if (at_origin) begin
            en_lat <= enable_i;
            fx_lat <= flip_x_i;
            fy_lat <= flip_y_i;
        end
    end

    // Decode the current position: visibility, raw syncs and the scaled,
    // clamped and optionally mirrored framebuffer coordinate.
    always_comb begin
        h_vis    = (h_cnt < H_BITS'(H_VIS_AREA_PXL));
        v_vis    = (v_cnt < V_BITS'(V_VIS_AREA_PXL));
        vis      = h_vis && v_vis;
        hs_raw   = (h_cnt >= H_BITS'(HS_START)) && ({1'b0, h_cnt} < (H_BITS + 1)'(HS_END));
        vs_raw   = (v_cnt >= V_BITS'(VS_START)) && ({1'b0, v_cnt} < (V_BITS + 1)'(VS_END));
        h_scaled = h_cnt >> SCALE_SHIFT;
        v_scaled = v_cnt >> SCALE_SHIFT;
        x_clamp  = (h_scaled > H_BITS'(FB_W - 1)) ? X_BITS'(FB_W - 1) : X_BITS'(h_scaled);
        y_clamp  = (v_scaled > V_BITS'(FB_H - 1)) ? Y_BITS'(FB_H - 1) : Y_BITS'(v_scaled);
        x_req    = frame_fx ? (X_BITS'(FB_W - 1) - x_clamp) : x_clamp;
        y_req    = frame_fy ? (Y_BITS'(FB_H - 1) - y_clamp) : y_clamp;
    end

    // Request stage: register the framebuffer read and the request-side status.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fb_rd_x_o     <= '0;
            fb_rd_y_o     <= '0;
            fb_rd_en_o    <= 1'b0;
            frame_start_o <= 1'b0;
            vblank_o      <= 1'b0;
        end else begin
            fb_rd_x_o     <= vis ? x_req : '0;
            fb_rd_y_o     <= vis ? y_req : '0;
            fb_rd_en_o    <= vis && frame_en;
            frame_start_o <= at_origin;
            vblank_o      <= !v_vis;
        end
    end

    // Delay line that realigns visibility, syncs and enable with returning colour.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vis_pipe <= '0;
            en_pipe  <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else begin
            vis_pipe <= {vis_pipe[L-2:0], vis};
            en_pipe  <= {en_pipe[L-2:0], frame_en};
            hs_pipe  <= {hs_pipe[L-2:0], hs_raw};
            vs_pipe  <= {vs_pipe[L-2:0], vs_raw};
        end
    end

    assign hs_d     = hs_pipe[L-1];
    assign vs_d     = vs_pipe[L-1];
    assign vga_hs_o = (HS_ACTIVE_HIGH != 0) ? hs_d : !hs_d;
    assign vga_vs_o = (VS_ACTIVE_HIGH != 0) ? vs_d : !vs_d;

    // Pick the pin colour: framebuffer data, border colour, or black in blanking.
    always_comb begin
        pixel = '0;
        if (vis_pipe[L-1]) begin
            pixel = en_pipe[L-1] ? color_i : border_color_i;
        end
    end

    assign vga_r_o = pixel[COLOR_BITS-1 -: RED_BITS];
    assign vga_g_o = pixel[GREEN_BITS+BLUE_BITS-1 -: GREEN_BITS];
    assign vga_b_o = pixel[BLUE_BITS-1:0];

endmodule

// File: tb/tb_video_scanout_controller.sv
// tb_video_scanout_controller
// Small raster (odd visible sizes, scale 2, read latency 3, active-low hsync)
// driven with random frame controls. A position-based reference model pushes
// expected request-side and pin-side values into queues; a monitor pops them
// every cycle. A framebuffer model answers the DUT's reads.
module tb_video_scanout_controller;

    localparam int HV = 21, HFP = 3, HSW = 4, HBP = 4;
    localparam int VV = 11, VFP = 2, VSW = 2, VBP = 3;
    localparam int HS_HIGH = 0, VS_HIGH = 1;
    localparam int SHIFT = 1, RDL = 3;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int L = 1 + RDL;
    localparam int FBW = HV >> SHIFT;
    localparam int FBH = VV >> SHIFT;
    localparam int XB = $clog2(FBW);
    localparam int YB = $clog2(FBH);

    typedef struct {
        int x;
        int y;
        bit en;
        bit fs;
        bit vb;
    } req_exp_t;

    typedef struct {
        bit          hs;
        bit          vs;
        bit          use_border;
        logic [11:0] rgb;
    } pin_exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          flip_x = 1'b0;
    logic          flip_y = 1'b0;
    logic [11:0]   border = 12'h000;
    logic [11:0]   color;
    logic [XB-1:0] rd_x;
    logic [YB-1:0] rd_y;
    logic          rd_en;
    logic          hs, vs;
    logic [3:0]    r, g, b;
    logic          frame_start, vblank;

    req_exp_t    req_q[$];
    pin_exp_t    pin_q[$];
    logic [11:0] fb_mem [FBW*FBH];
    logic [11:0] rd_pipe [RDL];

    int checks = 0;
    int errors = 0;
    int pos = 0;
    bit running = 1'b0;
    bit lat_en, lat_fx, lat_fy;

    always #5 clk = ~clk;

    video_scanout_controller #(
        .H_VIS_AREA_PXL(HV), .H_FRONT_PORCH_PXL(HFP), .H_SYNC_PULSE_PXL(HSW), .H_BACK_PORCH_PXL(HBP),
        .V_VIS_AREA_PXL(VV), .V_FRONT_PORCH_PXL(VFP), .V_SYNC_PULSE_PXL(VSW), .V_BACK_PORCH_PXL(VBP),
        .HS_ACTIVE_HIGH(HS_HIGH), .VS_ACTIVE_HIGH(VS_HIGH), .SCALE_SHIFT(SHIFT), .RD_LATENCY(RDL),
        .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .flip_x_i(flip_x), .flip_y_i(flip_y),
        .border_color_i(border), .fb_rd_x_o(rd_x), .fb_rd_y_o(rd_y), .fb_rd_en_o(rd_en),
        .color_i(color), .vga_hs_o(hs), .vga_vs_o(vs), .vga_r_o(r), .vga_g_o(g), .vga_b_o(b),
        .frame_start_o(frame_start), .vblank_o(vblank)
    );

    // Framebuffer model: answers a read RDL cycles after it is presented;
    // returns junk when no read is requested.
    function automatic logic [11:0] memRead(input int x, input int y, input bit en);
        if (en && x < FBW && y < FBH) return fb_mem[y*FBW + x];
        return 12'($urandom);
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= memRead(int'(rd_x), int'(rd_y), rd_en);
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign color = rd_pipe[RDL-1];

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, expected);
        end
    endtask

    // Drive random inputs for the current counter position and queue the
    // responses the display rules predict for it.
    task automatic applyStimulus();
        int h, v, fx, fy, fi;
        bit vis;
        req_exp_t rq;
        pin_exp_t pn;
        h  = pos % HT;
        v  = (pos / HT) % VT;
        fi = pos / FRAME;
        enable = ($urandom_range(0, 3) != 0);
        flip_x = 1'($urandom_range(0, 1));
        flip_y = 1'($urandom_range(0, 1));
        if (h == 0 && v == 0) begin
            case (fi)
                0: begin enable = 1'b0; flip_x = 1'b0; flip_y = 1'b0; border = 12'hF00; end
                1: begin enable = 1'b1; flip_x = 1'b0; flip_y = 1'b0; border = 12'($urandom); end
                2: begin enable = 1'b1; flip_x = 1'b1; flip_y = 1'b1; border = 12'($urandom); end
                default: border = 12'($urandom);
            endcase
            lat_en = enable;
            lat_fx = flip_x;
            lat_fy = flip_y;
        end
        vis = (h < HV) && (v < VV);
        fx = h / (1 << SHIFT);
        if (fx > FBW - 1) fx = FBW - 1;
        if (lat_fx) fx = FBW - 1 - fx;
        fy = v / (1 << SHIFT);
        if (fy > FBH - 1) fy = FBH - 1;
        if (lat_fy) fy = FBH - 1 - fy;
        rq.x  = vis ? fx : 0;
        rq.y  = vis ? fy : 0;
        rq.en = vis && lat_en;
        rq.fs = (h == 0 && v == 0);
        rq.vb = (v >= VV);
        req_q.push_back(rq);
        pn.hs = (h >= HV + HFP && h < HV + HFP + HSW) ? (HS_HIGH != 0) : (HS_HIGH == 0);
        pn.vs = (v >= VV + VFP && v < VV + VFP + VSW) ? (VS_HIGH != 0) : (VS_HIGH == 0);
        pn.use_border = vis && !lat_en;
        pn.rgb = (vis && lat_en) ? fb_mem[fy*FBW + fx] : 12'h000;
        pin_q.push_back(pn);
        pos++;
    endtask

    // Compare one cycle of DUT outputs with the oldest queued expectations.
    task automatic checkOutput();
        req_exp_t rq;
        pin_exp_t pn;
        logic [11:0] want;
        if (req_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL req_queue t=%0t actual=empty required=entry", $time);
        end else begin
            rq = req_q.pop_front();
            checkValue("fb_rd_en", int'(rd_en), int'(rq.en));
            checkValue("fb_rd_x", int'(rd_x), rq.x);
            checkValue("fb_rd_y", int'(rd_y), rq.y);
            checkValue("frame_start", int'(frame_start), int'(rq.fs));
            checkValue("vblank", int'(vblank), int'(rq.vb));
        end
        if (pin_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL pin_queue t=%0t actual=empty required=entry", $time);
        end else begin
            pn = pin_q.pop_front();
            want = pn.use_border ? border : pn.rgb;
            checkValue("vga_hs", int'(hs), int'(pn.hs));
            checkValue("vga_vs", int'(vs), int'(pn.vs));
            checkValue("vga_rgb", int'({r, g, b}), int'(want));
        end
    endtask

    // Everything must sit at its idle level while reset is held.
    task automatic resetChecks(input string tag);
        checkValue({tag, "_hs"}, int'(hs), (HS_HIGH != 0) ? 0 : 1);
        checkValue({tag, "_vs"}, int'(vs), (VS_HIGH != 0) ? 0 : 1);
        checkValue({tag, "_rgb"}, int'({r, g, b}), 0);
        checkValue({tag, "_rd_en"}, int'(rd_en), 0);
        checkValue({tag, "_rd_xy"}, int'({rd_x, rd_y}), 0);
        checkValue({tag, "_frame_start"}, int'(frame_start), 0);
        checkValue({tag, "_vblank"}, int'(vblank), 0);
    endtask

    // Release reset and restart the model at position (0,0); the first L-1
    // pin cycles still show the cleared delay line.
    task automatic startRun();
        pin_exp_t idle;
        req_q.delete();
        pin_q.delete();
        pos = 0;
        lat_en = 1'b0; lat_fx = 1'b0; lat_fy = 1'b0;
        idle.hs = (HS_HIGH == 0);
        idle.vs = (VS_HIGH == 0);
        idle.use_border = 1'b0;
        idle.rgb = 12'h000;
        for (int i = 0; i < L - 1; i++) pin_q.push_back(idle);
        reset_n = 1'b1;
        running = 1'b1;
    endtask

    // Monitor: checks every cycle, one time unit after the active edge.
    always begin
        @(posedge clk);
        #1;
        if (running) checkOutput();
    end

    // Stimulus sequence: power-on reset, eight frames, reset mid-sync, three frames.
    initial begin
        int target;
        for (int i = 0; i < FBW*FBH; i++) fb_mem[i] = 12'($urandom);
        repeat (3) @(negedge clk);
        resetChecks("por");
        startRun();
        for (int c = 0; c < 8*FRAME; c++) begin
            applyStimulus();
            @(negedge clk);
        end
        // land in the vsync line with hsync asserted on the pins
        target = (VV + VFP) * HT + HV + HFP + L + 1;
        while ((pos % FRAME) != target) begin
            applyStimulus();
            @(negedge clk);
        end
        running = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        resetChecks("midline");
        repeat (4) @(negedge clk);
        resetChecks("held");
        startRun();
        for (int c = 0; c < 3*FRAME; c++) begin
            applyStimulus();
            @(negedge clk);
        end
        running = 1'b0;
        $display("[TB] run complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
